// File: rtl/gf_pkg.sv
// Shared types, constants and helpers for the digit-serial GF(2^n) multiplier.
package gf_pkg;

  localparam int unsigned GF_MAX_WIDTH = 256;
  localparam logic [127:0] GF128_POLY = 128'h87;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } gf_state_e;

  // Reverses the low w bits of x; bits above w come back as zero.
  function automatic logic [GF_MAX_WIDTH-1:0] bit_rev(input logic [GF_MAX_WIDTH-1:0] x,
                                                       input int unsigned w);
    logic [GF_MAX_WIDTH-1:0] r;
    r = {<<{x}};
    return r >> (GF_MAX_WIDTH - w);
  endfunction

  function automatic bit digit_ok(input int unsigned width, input int unsigned digit);
    return (digit inside {1, 2, 4, 8, 16, 32}) && ((width % digit) == 0) &&
           (width <= GF_MAX_WIDTH) && ((width / digit) >= 2);
  endfunction

endpackage

// File: rtl/gf_mul_serial_if.sv
// Operand/result handshake bundle for gf_mul_serial.
interface gf_mul_serial_if #(
  parameter int unsigned WIDTH = 128
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_acc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  modport master (
    output in_valid, in_a, in_b, in_acc, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_acc, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/gf_digit_step.sv
// One MSB-first Horner step over DIGIT bits of b: p_next = p*x^DIGIT + a*d mod f.
module gf_digit_step
  import gf_pkg::*;
#(
  parameter int unsigned      WIDTH = 128,
  parameter int unsigned      DIGIT = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(GF128_POLY)
) (
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] a,
  input  logic [DIGIT-1:0] d,
  output logic [WIDTH-1:0] p_next
);

  logic [WIDTH-1:0] acc;
  logic [DIGIT-1:0] dd;

  // Each x^1 shift folds the carried-out term back in through POLY.
  always_comb begin
    acc = p;
    dd  = d;
    for (int unsigned j = 0; j < DIGIT; j++) begin
      acc = {acc[WIDTH-2:0], 1'b0} ^ (acc[WIDTH-1] ? POLY : '0);
      if (dd[DIGIT-1]) acc = acc ^ a;
      dd = dd << 1;
    end
    p_next = acc;
  end

endmodule

// File: rtl/gf_mul_serial.sv
// Handshaked digit-serial GF(2^WIDTH) multiplier with GHASH accumulate and GCM bit order.
module gf_mul_serial
  import gf_pkg::*;
#(
  parameter int unsigned      WIDTH     = 128,
  parameter int unsigned      DIGIT     = 8,
  parameter logic [WIDTH-1:0] POLY      = WIDTH'(GF128_POLY),
  parameter bit               GCM_ORDER = 1'b1
) (
  input logic            clk,
  input logic            rst,
  gf_mul_serial_if.slave bus
);

  localparam int unsigned      STEPS = WIDTH / DIGIT;
  localparam int unsigned      CNT_W = $clog2(STEPS);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(STEPS - 1);

  if (!digit_ok(WIDTH, DIGIT)) begin : g_bad_cfg
    $error("gf_mul_serial: illegal WIDTH/DIGIT combination");
  end

  // Reflection is its own inverse, so the same mapping serves entry and exit.
  function automatic logic [WIDTH-1:0] to_core(input logic [WIDTH-1:0] x);
    if (GCM_ORDER) return WIDTH'(bit_rev(GF_MAX_WIDTH'(x), WIDTH));
    return x;
  endfunction

  gf_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q, b_q, p_q, z_q, out_data_q, p_next;
  logic             in_ready_q, out_valid_q, busy_q;
  logic             load_c, step_c, last_c;

  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    step_c  = 1'b0;
    last_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          load_c  = 1'b1;
          state_d = MUL;
        end
      end
      MUL: begin
        step_c = 1'b1;
        if (cnt_q == LAST) begin
          last_c  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are registered copies of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  gf_digit_step #(
    .WIDTH(WIDTH),
    .DIGIT(DIGIT),
    .POLY (POLY)
  ) u_step (
    .p     (p_q),
    .a     (a_q),
    .d     (b_q[WIDTH-1 -: DIGIT]),
    .p_next(p_next)
  );

  // Z is kept in core order so the accumulate XOR needs no extra reversal.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      p_q        <= '0;
      z_q        <= '0;
      out_data_q <= '0;
    end else begin
      if (load_c) begin
        a_q   <= (bus.in_acc ? z_q : '0) ^ to_core(bus.in_a);
        b_q   <= to_core(bus.in_b);
        p_q   <= '0;
        cnt_q <= '0;
      end else if (step_c) begin
        p_q   <= p_next;
        b_q   <= b_q << DIGIT;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (last_c) begin
        z_q        <= p_next;
        out_data_q <= to_core(p_next);
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_gf_mul_serial.sv
// Directed-vector bench for gf_mul_serial across several DIGIT/order configurations.
module tb_gf_mul_serial;

  localparam int unsigned W    = 128;
  localparam int unsigned NCFG = 6;
  localparam int unsigned DIG [NCFG] = '{8, 8, 1, 32, 4, 16};
  localparam bit          ORD [NCFG] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam logic [W-1:0] POLY = 128'h87;

  localparam logic [W-1:0] GC  = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [W-1:0] GH  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [W-1:0] GX1 = 128'h5e2ec746917062882c85b0685353deb7;
  localparam logic [W-1:0] GX2 = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
  localparam logic [W-1:0] LEN = 128'h00000000000000000000000000000080;
  localparam logic [W-1:0] MSB = 128'h80000000000000000000000000000000;
  localparam logic [W-1:0] KA  = 128'h0123456789abcdeffedcba9876543210;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NCFG-1:0] in_valid, out_ready, in_ready, out_valid, busy;
  logic [W-1:0]    in_a, in_b;
  logic            in_acc;
  logic [W-1:0]    out_data [NCFG];

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    gf_mul_serial_if #(.WIDTH(W)) bus ();
    assign bus.in_valid  = in_valid[g];
    assign bus.in_a      = in_a;
    assign bus.in_b      = in_b;
    assign bus.in_acc    = in_acc;
    assign bus.out_ready = out_ready[g];
    assign in_ready[g]   = bus.in_ready;
    assign out_valid[g]  = bus.out_valid;
    assign out_data[g]   = bus.out_data;
    assign busy[g]       = bus.busy;

    gf_mul_serial #(
      .WIDTH    (W),
      .DIGIT    (DIG[g]),
      .POLY     (POLY),
      .GCM_ORDER(ORD[g])
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] z_model [NCFG];

  typedef struct {
    int           c;
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           acc;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rev(input logic [W-1:0] x);
    logic [W-1:0] r;
    r = {<<{x}};
    return r;
  endfunction

  // LSB-first shift-and-add reference product.
  function automatic logic [W-1:0] gf_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input bit ord);
    logic [W-1:0] aa, bb, r;
    aa = ord ? rev(a) : a;
    bb = ord ? rev(b) : b;
    r  = '0;
    for (int i = 0; i < W; i++) begin
      if (bb[0]) r = r ^ aa;
      bb = bb >> 1;
      aa = {aa[W-2:0], 1'b0} ^ (aa[W-1] ? POLY : '0);
    end
    return ord ? rev(r) : r;
  endfunction

  // Issues one operation on config c, holds out_ready low for `hold` cycles in DONE.
  task automatic run_op(input int c, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit acc, input int hold, output logic [W-1:0] res);
    int n;
    @(negedge clk);
    check("in_ready_at_issue", W'(in_ready[c]), W'(1));
    in_a = a; in_b = b; in_acc = acc;
    in_valid[c]  = 1'b1;
    out_ready[c] = (hold == 0);
    @(negedge clk);
    in_valid[c] = 1'b0;
    in_a = ~a; in_b = ~b; in_acc = ~acc;
    n = 0;
    while (!out_valid[c] && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("latency", W'(n), W'(W / DIG[c]));
    res = out_data[c];
    for (int i = 0; i < hold; i++) @(negedge clk);
    out_ready[c] = 1'b1;
    @(negedge clk);
    check("out_valid_after_ack", W'(out_valid[c]), W'(0));
    check("in_ready_after_ack", W'(in_ready[c]), W'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] res, exp, held, ra, rb;
    bit racc;
    int n;

    rst = 1'b1; in_valid = '0; out_ready = '0;
    in_a = '0; in_b = '0; in_acc = 1'b0;
    for (int c = 0; c < NCFG; c++) z_model[c] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < NCFG; c++) begin
      check("rst_in_ready", W'(in_ready[c]), W'(1));
      check("rst_out_valid", W'(out_valid[c]), W'(0));
      check("rst_busy", W'(busy[c]), W'(0));
      check("rst_out_data", out_data[c], '0);
    end
    rst = 1'b0;

    tbl.push_back('{0, 128'h2, MSB, 1'b0, 128'h87});
    tbl.push_back('{4, 128'h2, MSB, 1'b0, 128'h87});
    tbl.push_back('{4, KA, 128'h1, 1'b0, KA});
    for (int c = 1; c < NCFG; c++) begin
      if (c == 4) continue;
      tbl.push_back('{c, GC, GH, 1'b0, GX1});
      tbl.push_back('{c, LEN, GH, 1'b1, GX2});
      tbl.push_back('{c, KA, MSB, 1'b0, KA});
      tbl.push_back('{c, '0, GH, 1'b0, '0});
      tbl.push_back('{c, KA, '0, 1'b0, '0});
    end
    foreach (tbl[i]) begin
      run_op(tbl[i].c, tbl[i].a, tbl[i].b, tbl[i].acc, 0, res);
      check($sformatf("vec%0d_cfg%0d", i, tbl[i].c), res, tbl[i].exp);
      z_model[tbl[i].c] = tbl[i].exp;
    end

    // Backpressure: result held while DONE, stray in_valid ignored.
    exp = gf_ref(KA, GH, 1'b1);
    @(negedge clk);
    in_a = KA; in_b = GH; in_acc = 1'b0;
    in_valid[1] = 1'b1; out_ready[1] = 1'b0;
    @(negedge clk);
    in_valid[1] = 1'b0;
    n = 0;
    while (!out_valid[1] && n < 300) begin
      @(negedge clk);
      n++;
    end
    held = out_data[1];
    check("bp_result", held, exp);
    for (int i = 0; i < 10; i++) begin
      in_valid[1] = i[0];
      in_a = {4{$urandom}}; in_b = {4{$urandom}}; in_acc = 1'b1;
      @(negedge clk);
      check("bp_out_valid", W'(out_valid[1]), W'(1));
      check("bp_out_data", out_data[1], held);
      check("bp_in_ready", W'(in_ready[1]), W'(0));
    end
    in_valid[1] = 1'b0; out_ready[1] = 1'b1;
    @(negedge clk);
    check("bp_release_valid", W'(out_valid[1]), W'(0));
    check("bp_release_ready", W'(in_ready[1]), W'(1));
    check("bp_release_busy", W'(busy[1]), W'(0));
    z_model[1] = exp;
    exp = gf_ref(z_model[1] ^ GC, GH, 1'b1);
    run_op(1, GC, GH, 1'b1, 0, res);
    check("bp_next_op", res, exp);
    z_model[1] = exp;

    // Reset with cnt at 5 in MUL.
    @(negedge clk);
    in_a = GC; in_b = GH; in_acc = 1'b0; in_valid[1] = 1'b1;
    @(negedge clk);
    in_valid[1] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_in_ready", W'(in_ready[1]), W'(1));
    check("mid_rst_out_valid", W'(out_valid[1]), W'(0));
    check("mid_rst_busy", W'(busy[1]), W'(0));
    check("mid_rst_out_data", out_data[1], '0);
    for (int c = 0; c < NCFG; c++) z_model[c] = '0;
    run_op(1, GC, GH, 1'b1, 0, res);
    check("post_rst_acc", res, GX1);
    z_model[1] = GX1;

    // Short random run with gaps and backpressure against the reference.
    for (int c = 0; c < NCFG; c++) begin
      for (int k = 0; k < 6; k++) begin
        ra = {$urandom, $urandom, $urandom, $urandom};
        rb = {$urandom, $urandom, $urandom, $urandom};
        racc = 1'($urandom_range(0, 1));
        repeat ($urandom_range(0, 2)) @(negedge clk);
        exp = gf_ref(racc ? (z_model[c] ^ ra) : ra, rb, ORD[c]);
        run_op(c, ra, rb, racc, int'($urandom_range(0, 3)), res);
        check($sformatf("rand_cfg%0d_%0d", c, k), res, exp);
        z_model[c] = exp;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
